// File: rtl/proc_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_io_pkg
// Description : Shared constants and types for the processor timer peripheral:
//               register offsets, CTRL/STATUS bit indices and the timer state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_io_pkg;

    // Register offsets within the 8-word window
    localparam logic [2:0] OFS_CTRL   = 3'd0;
    localparam logic [2:0] OFS_LOAD   = 3'd1;
    localparam logic [2:0] OFS_COUNT  = 3'd2;
    localparam logic [2:0] OFS_STATUS = 3'd3;
    localparam logic [2:0] OFS_PRESC  = 3'd4;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IE     = 2;

    // STATUS bit positions
    localparam int STATUS_EXP  = 0;

    // Timer state; EN reads 1 only in RUN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage
`default_nettype wire

// File: rtl/proc_timer_presc.sv
`default_nettype none
// ============================================================================
// Module      : proc_timer_presc
// Description : Prescaler counter. Counts cycles while run is high and emits a
//               one-cycle tick when the count equals presc, wrapping to 0.
//               clr restarts the period from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_timer_presc #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] r_cnt;

    // The tick fires in the cycle the counter reaches the terminal value
    assign tick = run & (r_cnt == presc);

    // Prescaler counter: clear wins, then wrap on tick, else count while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= r_cnt + PRESC_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/proc_timer.sv
`default_nettype none
// ============================================================================
// Module      : proc_timer
// Description : Memory-mapped 16-bit down-counter timer with prescaler,
//               auto-reload and level interrupt. Read data is registered so it
//               returns one cycle after the address, like the data memory.
//               Build option: define PROC_TIMER_IRQ_EN to implement CTRL.IE
//               and the irq output; otherwise IE reads 0 and irq is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_timer
    import proc_io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h1000,
    parameter int          PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] dout,
    input  logic        wren,
    output logic [15:0] rdata,
    output logic        hit,
    output logic        irq
);

    timer_state_t       r_state;
    logic [15:0]        r_count;
    logic [15:0]        r_load;
    logic [PRESC_W-1:0] r_presc;
    logic               r_reload;
    logic               r_exp;
    logic               w_ie;
    logic [15:0]        r_rdata;
    logic               r_hit;

    logic               w_sel;
    logic [2:0]         w_ofs;
    logic               w_wr;
    logic               w_wr_ctrl;
    logic               w_wr_load;
    logic               w_wr_count;
    logic               w_wr_status;
    logic               w_wr_presc;
    logic               w_start;
    logic               w_stop;
    logic               w_tick;
    logic               w_expire;
    logic [15:0]        w_presc_ext;
    logic [15:0]        w_rd_val;

    assign w_sel       = (addr[15:3] == BASE_ADDR[15:3]);
    assign w_ofs       = addr[2:0];
    assign w_wr        = wren & w_sel;
    assign w_wr_ctrl   = w_wr & (w_ofs == OFS_CTRL);
    assign w_wr_load   = w_wr & (w_ofs == OFS_LOAD);
    assign w_wr_count  = w_wr & (w_ofs == OFS_COUNT);
    assign w_wr_status = w_wr & (w_ofs == OFS_STATUS);
    assign w_wr_presc  = w_wr & (w_ofs == OFS_PRESC);

    // Enabling from IDLE or DONE restarts; enabling while RUN is a no-op
    assign w_start  = w_wr_ctrl & dout[CTRL_EN] & (r_state != RUN);
    assign w_stop   = w_wr_ctrl & ~dout[CTRL_EN] & (r_state == RUN);

    // A COUNT write or a stop in the same cycle suppresses the tick's effect
    assign w_expire = (r_state == RUN) & w_tick & ~w_stop & ~w_wr_count
                    & (r_count == 16'd0);

    proc_timer_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .run   (r_state == RUN),
        .clr   (w_start | w_wr_count),
        .presc (r_presc),
        .tick  (w_tick)
    );

    // Timer FSM with count register and expiry flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_exp   <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_stop) begin
                        r_state <= IDLE;
                    end else if (w_wr_count) begin
                        r_count <= dout;
                    end else if (w_tick) begin
                        if (r_count != 16'd0) begin
                            r_count <= r_count - 16'd1;
                        end else if (r_reload) begin
                            r_count <= r_load;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                default: begin
                    if (w_start) begin
                        r_state <= RUN;
                        r_count <= r_load;
                    end else if (w_wr_count) begin
                        r_count <= dout;
                    end
                end
            endcase
            // Expiry beats a simultaneous write-1-to-clear
            if (w_expire) begin
                r_exp <= 1'b1;
            end else if (w_wr_status & dout[STATUS_EXP]) begin
                r_exp <= 1'b0;
            end
        end
    end

    // Software-written configuration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reload <= 1'b0;
            r_load   <= '0;
            r_presc  <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_reload <= dout[CTRL_RELOAD];
            end
            if (w_wr_load) begin
                r_load <= dout;
            end
            if (w_wr_presc) begin
                r_presc <= dout[PRESC_W-1:0];
            end
        end
    end

`ifdef PROC_TIMER_IRQ_EN
    logic r_ie;

    // Interrupt enable bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ie <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_ie <= dout[CTRL_IE];
        end
    end

    assign w_ie = r_ie;
`else
    assign w_ie = 1'b0;
`endif

    assign irq = r_exp & w_ie;

    // Read mux over the current (pre-edge) register values
    always_comb begin
        w_presc_ext                = '0;
        w_presc_ext[PRESC_W-1:0]   = r_presc;
        w_rd_val                   = '0;
        case (w_ofs)
            OFS_CTRL:   w_rd_val = {13'd0, w_ie, r_reload, (r_state == RUN)};
            OFS_LOAD:   w_rd_val = r_load;
            OFS_COUNT:  w_rd_val = r_count;
            OFS_STATUS: w_rd_val = {15'd0, r_exp};
            OFS_PRESC:  w_rd_val = w_presc_ext;
            default:    w_rd_val = '0;
        endcase
    end

    // One-cycle read latency, zero data outside the window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_hit   <= 1'b0;
        end else begin
            r_rdata <= w_sel ? w_rd_val : 16'd0;
            r_hit   <= w_sel;
        end
    end

    assign rdata = r_rdata;
    assign hit   = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_proc_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_timer
// Description : Scoreboard bench for proc_timer. Reads push their expected
//               response; a monitor pops and compares one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_timer;

    localparam logic [15:0] BASE = 16'h1000;
`ifdef PROC_TIMER_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    typedef struct {
        logic        hit;
        logic [15:0] data;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        wren;
    logic [15:0] rdata;
    logic        hit;
    logic        irq;
    logic        rd_issue;
    logic        rd_resp;

    int   total;
    int   bad;
    exp_t sb[$];

    proc_timer #(
        .BASE_ADDR (BASE),
        .PRESC_W   (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .dout  (dout),
        .wren  (wren),
        .rdata (rdata),
        .hit   (hit),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    // Read responses arrive one edge after the read is issued
    always @(posedge clk or posedge rst) begin
        if (rst) rd_resp <= 1'b0;
        else     rd_resp <= rd_issue;
    end

    // Monitor: compare each read response against the scoreboard head
    always @(negedge clk) begin
        if (rd_resp) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read: actual=response required=none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, ".hit"}, {15'd0, hit}, {15'd0, e.hit});
                check(e.name, rdata, e.data);
            end
        end
    end

    // One bus cycle, ending on the following falling edge
    task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic we, input logic rd);
        addr     = a;
        dout     = d;
        wren     = we;
        rd_issue = rd;
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] ofs, input logic [15:0] d);
        cyc(BASE + {13'd0, ofs}, d, 1'b1, 1'b0);
    endtask

    task automatic rd_at(input logic [15:0] a, input logic eh, input logic [15:0] ed, input string nm);
        exp_t e;
        e.hit  = eh;
        e.data = ed;
        e.name = nm;
        sb.push_back(e);
        cyc(a, 16'd0, 1'b0, 1'b1);
    endtask

    task automatic rd(input logic [2:0] ofs, input logic [15:0] ed, input string nm);
        rd_at(BASE + {13'd0, ofs}, 1'b1, ed, nm);
    endtask

    task automatic idle();
        cyc(16'h0000, 16'd0, 1'b0, 1'b0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        addr     = 16'd0;
        dout     = 16'd0;
        wren     = 1'b0;
        rd_issue = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_rdata", rdata, 16'd0);
        check("reset_hit", {15'd0, hit}, 16'd0);
        check("reset_irq", {15'd0, irq}, 16'd0);

        // One-shot: PRESC=0, LOAD=3, CTRL=EN|IE; expiry 4 edges after enable
        wr(3'd4, 16'd0);
        wr(3'd1, 16'd3);
        wr(3'd0, 16'd5);
        rd(3'd0, IRQ_ON ? 16'd5 : 16'd1, "os_ctrl_run");
        rd(3'd3, 16'd0, "os_status_e2");
        rd(3'd3, 16'd0, "os_status_e3");
        check("os_irq_before", {15'd0, irq}, 16'd0);
        rd(3'd3, 16'd0, "os_status_e4");
        check("os_irq_expiry", {15'd0, irq}, {15'd0, IRQ_ON});
        rd(3'd3, 16'd1, "os_status_exp");
        rd(3'd0, IRQ_ON ? 16'd4 : 16'd0, "os_ctrl_done");
        rd(3'd2, 16'd0, "os_count_done");
        wr(3'd3, 16'd1);
        rd(3'd3, 16'd0, "os_status_clr");
        check("os_irq_clr", {15'd0, irq}, 16'd0);

        // Auto-reload: PRESC=1, LOAD=2, CTRL=EN|RELOAD; expiries every 6 cycles
        wr(3'd4, 16'd1);
        wr(3'd1, 16'd2);
        wr(3'd0, 16'd3);
        for (int i = 0; i < 6; i++) rd(3'd3, 16'd0, "ar_status_pre");
        rd(3'd2, 16'd2, "ar_count_reload");
        rd(3'd3, 16'd1, "ar_status_exp1");
        wr(3'd3, 16'd1);
        for (int i = 0; i < 3; i++) rd(3'd3, 16'd0, "ar_status_wait");
        rd(3'd3, 16'd1, "ar_status_exp2");
        wr(3'd3, 16'd1);
        rd(3'd3, 16'd0, "ar_status_clr2");
        idle();
        idle();
        wr(3'd3, 16'd1);
        rd(3'd3, 16'd1, "collision_set_wins");
        idle();
        wr(3'd0, 16'd2);
        rd(3'd2, 16'd1, "stop_count");
        idle();
        rd(3'd2, 16'd1, "stop_count_held");
        rd(3'd0, 16'd2, "stop_ctrl");

        // COUNT write beats a tick; re-enable while running does not restart
        wr(3'd4, 16'd0);
        wr(3'd1, 16'd10);
        wr(3'd0, 16'd1);
        wr(3'd2, 16'd7);
        rd(3'd2, 16'd7, "cw_write_wins");
        rd(3'd2, 16'd6, "cw_decrement");
        wr(3'd0, 16'd1);
        rd(3'd2, 16'd4, "no_restart");
        wr(3'd0, 16'd0);

        // Window and read latency
        wr(3'd1, 16'hABCD);
        rd(3'd1, 16'hABCD, "win_load");
        wr(3'd6, 16'h5555);
        rd(3'd6, 16'd0, "win_ofs6");
        rd_at(BASE + 16'd8, 1'b0, 16'd0, "win_outside");
        wr(3'd4, 16'h8001);
        rd(3'd4, 16'h8001, "win_presc");

        // Asynchronous reset while running with COUNT=5
        wr(3'd4, 16'd3);
        wr(3'd1, 16'd5);
        wr(3'd0, 16'd5);
        idle();
        rd(3'd2, 16'd5, "rst_pre_count");
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_hit", {15'd0, hit}, 16'd0);
        check("rst_async_irq", {15'd0, irq}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        rd(3'd0, 16'd0, "rst_ctrl");
        rd(3'd1, 16'd0, "rst_load");
        rd(3'd2, 16'd0, "rst_count");
        rd(3'd3, 16'd0, "rst_status");
        rd(3'd4, 16'd0, "rst_presc");
        idle();
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: actual=%0d pending required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
